// File: rtl/tcm_dec_demapper.sv
// 4D-8PSK TCM receive demapper: gathers four hard-decision 8PSK symbols and inverts the mod-8 mapping.
// Optional macro TCM_DEC_DEMAPPER_ERR_CNT_EN adds a per-frame saturating mapping-error counter output.
module tcm_dec_demapper (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iclkena,
  input  logic [1:0]  icode,
  input  logic        i1sps,
  input  logic        isop,
  input  logic        ieop,
  input  logic        ival,
  input  logic [2:0]  idat,
  output logic        oval,
  output logic        osop,
  output logic        oeop,
  output logic [11:0] odat,
  output logic        oerr
`ifdef TCM_DEC_DEMAPPER_ERR_CNT_EN
  ,
  output logic [15:0] oerr_cnt
`endif
);

  localparam int unsigned SYM_W  = 3;
  localparam int unsigned WORD_W = 12;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SYM_W-1:0]   z0, z1, z2;
  logic [1:0]         code_q;
  logic               sop_q;
  logic               start, store, fire;

  logic [SYM_W-1:0]   d1, d2, d3;
  logic [WORD_W-1:0]  dec_word;
  logic               dec_err;

  // state register
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)       state <= IDLE;
    else if (iclkena) state <= state_nxt;
  end

  // next state; an ival strobe always restarts a group, dropping any partial one
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    store     = 1'b0;
    fire      = 1'b0;
    if (i1sps) begin
      case (state)
        IDLE: begin
          if (ival) begin
            start     = 1'b1;
            state_nxt = COLLECT;
          end
        end
        COLLECT: begin
          if (ival) begin
            start = 1'b1;
          end else if (cnt == CNT_W'(3)) begin
            fire      = 1'b1;
            state_nxt = IDLE;
          end else begin
            store = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // symbol capture; code rate and sop are frozen for the whole group
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      cnt    <= '0;
      z0     <= '0;
      z1     <= '0;
      z2     <= '0;
      code_q <= '0;
      sop_q  <= 1'b0;
    end else if (iclkena) begin
      if (start) begin
        z0     <= idat;
        code_q <= icode;
        sop_q  <= isop;
        cnt    <= CNT_W'(1);
      end else if (store) begin
        if (cnt == CNT_W'(1)) z1 <= idat;
        else                  z2 <= idat;
        cnt <= cnt + CNT_W'(1);
      end else if (fire) begin
        cnt <= '0;
      end
    end
  end

  // inverse mapping with the live symbol as z3; all arithmetic wraps mod 8
  always_comb begin
    d1       = z1 - z0;
    d2       = z2 - z0;
    d3       = '0;
    dec_word = '0;
    dec_err  = 1'b0;
    case (code_q)
      2'd0: begin
        d3       = idat - z1 - z2 + z0;
        dec_word = {3'b000, z0[2], d1[2], d2[2], z0[1], d3[2], d1[1], d2[1], z0[0], d3[1]};
        dec_err  = d1[0] | d2[0] | d3[0];
      end
      2'd1: begin
        d3       = idat - z0 - {d1[2:1], 1'b0} - d2;
        dec_word = {2'b00, z0[2], d1[2], d2[2], z0[1], d3[2], d1[1], d2[1], z0[0], d3[1], d1[0]};
        dec_err  = d2[0] | (d3[0] ^ d1[0]);
      end
      2'd2: begin
        d3       = idat - z0 - d1 - d2;
        dec_word = {1'b0, z0[2], d1[2], d2[2], z0[1], d3[2], d1[1], d2[1], z0[0], d3[1], d1[0], d2[0]};
        dec_err  = d3[0];
      end
      default: begin
        d3       = idat - z0 - d1 - d2;
        dec_word = {z0[2], d1[2], d2[2], z0[1], d3[2], d1[1], d2[1], z0[0], d3[1], d1[0], d2[0], d3[0]};
        dec_err  = 1'b0;
      end
    endcase
  end

  // output registers; odat/oerr hold between pulses
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
      odat <= '0;
      oerr <= 1'b0;
    end else if (iclkena) begin
      oval <= fire;
      osop <= fire & sop_q;
      oeop <= fire & ieop;
      if (fire) begin
        odat <= dec_word;
        oerr <= dec_err;
      end
    end
  end

`ifdef TCM_DEC_DEMAPPER_ERR_CNT_EN
  localparam int unsigned ECNT_W = 16;

  logic [ECNT_W-1:0] err_acc, err_base_c, err_next_c;

  assign err_base_c = sop_q ? '0 : err_acc;
  assign err_next_c = (dec_err && (err_base_c != {ECNT_W{1'b1}})) ? err_base_c + ECNT_W'(1) : err_base_c;

  // running count restarts on a sop group and is published at frame end
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      err_acc  <= '0;
      oerr_cnt <= '0;
    end else if (iclkena && fire) begin
      err_acc <= err_next_c;
      if (ieop) oerr_cnt <= err_next_c;
    end
  end
`endif

endmodule

// File: tb/tb_tcm_dec_demapper.sv
// Directed bench for tcm_dec_demapper with hand-computed 4D words and immediate-assertion checks.
module tb_tcm_dec_demapper;

  logic        iclk = 1'b0;
  logic        ireset = 1'b1;
  logic        iclkena = 1'b1;
  logic [1:0]  icode = 2'd0;
  logic        i1sps = 1'b0;
  logic        isop = 1'b0;
  logic        ieop = 1'b0;
  logic        ival = 1'b0;
  logic [2:0]  idat = 3'd0;
  logic        oval, osop, oeop, oerr;
  logic [11:0] odat;
`ifdef TCM_DEC_DEMAPPER_ERR_CNT_EN
  logic [15:0] oerr_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  tcm_dec_demapper dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .icode   (icode),
    .i1sps   (i1sps),
    .isop    (isop),
    .ieop    (ieop),
    .ival    (ival),
    .idat    (idat),
    .oval    (oval),
    .osop    (osop),
    .oeop    (oeop),
    .odat    (odat),
    .oerr    (oerr)
`ifdef TCM_DEC_DEMAPPER_ERR_CNT_EN
    ,
    .oerr_cnt(oerr_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one strobed symbol, driven just after a falling edge, returns at the next falling edge
  task automatic send(input logic [2:0] d, input logic v, input logic s, input logic e, input logic [1:0] c);
    idat  = d;
    ival  = v;
    isop  = s;
    ieop  = e;
    icode = c;
    i1sps = 1'b1;
    @(negedge iclk);
    i1sps = 1'b0;
    ival  = 1'b0;
    isop  = 1'b0;
    ieop  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iclk);
  endtask

  initial begin
    @(negedge iclk);
    chk("rst_oval", 16'(oval), 16'h0);
    chk("rst_odat", 16'(odat), 16'h0);
    chk("rst_oerr", 16'(oerr), 16'h0);
    ireset = 1'b0;
    idle(2);

    // code 0, clean group, single-group frame
    send(3'd7, 1, 1, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    chk("c0_pre_oval", 16'(oval), 16'h0);
    send(3'd1, 0, 0, 1, 2'd0);
    chk("c0_oval", 16'(oval), 16'h1);
    chk("c0_odat", 16'(odat), 16'h1FF);
    chk("c0_oerr", 16'(oerr), 16'h0);
    chk("c0_osop", 16'(osop), 16'h1);
    chk("c0_oeop", 16'(oeop), 16'h1);
    idle(1);
    chk("c0_pulse_end", 16'({oval, osop, oeop}), 16'h0);
    chk("c0_hold", 16'(odat), 16'h1FF);

    // code 0, LSB violation
    send(3'd7, 1, 0, 0, 2'd0);
    send(3'd4, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd1, 0, 0, 0, 2'd0);
    chk("c0e_oval", 16'(oval), 16'h1);
    chk("c0e_odat", 16'(odat), 16'h1F7);
    chk("c0e_oerr", 16'(oerr), 16'h1);
    chk("c0e_sopeop", 16'({osop, oeop}), 16'h0);
    idle(1);

    // code 3, all ones then all zeros, back to back
    send(3'd7, 1, 0, 0, 2'd3);
    send(3'd6, 0, 0, 0, 2'd3);
    send(3'd6, 0, 0, 0, 2'd3);
    send(3'd4, 0, 0, 0, 2'd3);
    chk("c3a_odat", 16'(odat), 16'hFFF);
    chk("c3a_oerr", 16'(oerr), 16'h0);
    send(3'd0, 1, 0, 0, 2'd3);
    chk("c3_gap_oval", 16'(oval), 16'h0);
    send(3'd0, 0, 0, 0, 2'd3);
    send(3'd0, 0, 0, 0, 2'd3);
    send(3'd0, 0, 0, 0, 2'd3);
    chk("c3b_oval", 16'(oval), 16'h1);
    chk("c3b_odat", 16'(odat), 16'h000);
    idle(1);

    // code 2, with and without d3 LSB error
    send(3'd1, 1, 0, 0, 2'd2);
    send(3'd2, 0, 0, 0, 2'd2);
    send(3'd4, 0, 0, 0, 2'd2);
    send(3'd7, 0, 0, 0, 2'd2);
    chk("c2a_odat", 16'(odat), 16'h01F);
    chk("c2a_oerr", 16'(oerr), 16'h0);
    send(3'd1, 1, 0, 0, 2'd2);
    send(3'd2, 0, 0, 0, 2'd2);
    send(3'd4, 0, 0, 0, 2'd2);
    send(3'd0, 0, 0, 0, 2'd2);
    chk("c2b_odat", 16'(odat), 16'h01F);
    chk("c2b_oerr", 16'(oerr), 16'h1);
    idle(1);

    // early restart: ival on stream symbols 1 and 3
    send(3'd0, 1, 0, 0, 2'd0);
    send(3'd3, 0, 0, 0, 2'd0);
    send(3'd7, 1, 0, 0, 2'd0);
    chk("rs_oval_s3", 16'(oval), 16'h0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    chk("rs_oval_s5", 16'(oval), 16'h0);
    chk("rs_odat_held", 16'(odat), 16'h01F);
    send(3'd1, 0, 0, 0, 2'd0);
    chk("rs_oval", 16'(oval), 16'h1);
    chk("rs_odat", 16'(odat), 16'h1FF);
    idle(1);

    // restart in place of the 4th symbol
    send(3'd2, 1, 0, 0, 2'd3);
    send(3'd2, 0, 0, 0, 2'd3);
    send(3'd2, 0, 0, 0, 2'd3);
    send(3'd7, 1, 0, 0, 2'd0);
    chk("rs4_oval", 16'(oval), 16'h0);
    send(3'd4, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd1, 0, 0, 0, 2'd0);
    chk("rs4_odat", 16'(odat), 16'h1F7);
    chk("rs4_oerr", 16'(oerr), 16'h1);
    idle(1);

    // code latched at group start: 0 then 2 mid-group
    send(3'd7, 1, 0, 0, 2'd0);
    send(3'd4, 0, 0, 0, 2'd2);
    send(3'd5, 0, 0, 0, 2'd2);
    send(3'd1, 0, 0, 0, 2'd2);
    chk("lat_odat", 16'(odat), 16'h1F7);
    chk("lat_oerr", 16'(oerr), 16'h1);
    idle(1);

    // code 1 with strobe gap and clock-enable freeze mid-group
    send(3'd3, 1, 0, 0, 2'd1);
    send(3'd6, 0, 0, 0, 2'd1);
    idat = 3'd5;
    idle(5);
    iclkena = 1'b0;
    i1sps   = 1'b1;
    ival    = 1'b1;
    idat    = 3'd2;
    idle(5);
    i1sps   = 1'b0;
    ival    = 1'b0;
    iclkena = 1'b1;
    send(3'd1, 0, 0, 0, 2'd1);
    chk("stall_oval_mid", 16'(oval), 16'h0);
    send(3'd4, 0, 0, 0, 2'd1);
    chk("stall_oval", 16'(oval), 16'h1);
    chk("stall_odat", 16'(odat), 16'h0DD);
    chk("stall_oerr", 16'(oerr), 16'h0);
    idle(1);

    // async reset mid-group loses the partial group
    send(3'd7, 1, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    #2 ireset = 1'b1;
    #2 ireset = 1'b0;
    @(negedge iclk);
    chk("ar_odat", 16'(odat), 16'h0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd1, 0, 0, 0, 2'd0);
    chk("ar_no_oval", 16'(oval), 16'h0);
    send(3'd7, 1, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd1, 0, 0, 0, 2'd0);
    chk("ar_fresh_odat", 16'(odat), 16'h1FF);
    idle(1);

`ifdef TCM_DEC_DEMAPPER_ERR_CNT_EN
    // three-group frame: error, clean, error
    send(3'd7, 1, 1, 0, 2'd0);
    send(3'd4, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd1, 0, 0, 0, 2'd0);
    send(3'd7, 1, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd1, 0, 0, 0, 2'd0);
    chk("ecnt_pre", oerr_cnt, 16'h0);
    send(3'd7, 1, 0, 0, 2'd0);
    send(3'd4, 0, 0, 0, 2'd0);
    send(3'd5, 0, 0, 0, 2'd0);
    send(3'd1, 0, 0, 1, 2'd0);
    chk("ecnt_eop", oerr_cnt, 16'h2);
    idle(1);
    chk("ecnt_hold", oerr_cnt, 16'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tcm_dec_demapper.md
Name: tcm_dec_demapper

Overview:
- Receive-side inverse of the 4D-8PSK TCM encoder/mapper.
- Collects four hard-decision 8PSK symbols (one 4D group) from the symbol-rate interface.
- Inverts the mod-8 mapping for the selected code rate and emits one 12-bit 4D word per group, plus a mapping-consistency error flag.
- Sits after the hard slicer and before the TCM/frame decoder.

Parameters:
- none (widths fixed: 3-bit 8PSK symbol, 12-bit 4D word)

Ports:
- iclk     in   1   clock
- ireset   in   1   reset, asynchronous, active-high
- iclkena  in   1   clock enable; all state frozen when low
- icode    in   2   code rate 0/1/2/3 = 2/2.25/2.5/2.75 bit/symb
- i1sps    in   1   8PSK symbol strobe; one symbol per strobe
- isop     in   1   start of frame; valid with ival
- ieop     in   1   end of frame; valid on 4th symbol of the group
- ival     in   1   marks 1st 8PSK symbol of a 4D group; qualified by i1sps
- idat     in   3   8PSK symbol index
- oval     out  1   one-iclk pulse, 4D word valid
- osop     out  1   first 4D word of frame
- oeop     out  1   last 4D word of frame
- odat     out  12  recovered 4D word; unused MSBs are 0
- oerr     out  1   mapping LSB consistency violated for this word

Behaviour:
- Reset values: oval=0, osop=0, oeop=0, odat=0, oerr=0; FSM=IDLE, cnt=0.
- No action unless iclkena=1. Symbols are accepted only on i1sps=1.
- FSM IDLE: i1sps&ival → z0<=idat, code<=icode, sop<=isop, cnt<=1, go COLLECT. i1sps&!ival → ignored.
- FSM COLLECT:
  - i1sps&!ival, cnt=1 or 2 → z[cnt]<=idat, cnt++.
  - i1sps&!ival, cnt=3 → decode with idat as z3, register outputs, go IDLE.
  - i1sps&ival (early restart) → partial group discarded with no output; restart as in IDLE with the new symbol as z0.
- Latency: oval high exactly one iclk after the edge sampling z3. oval low on every other cycle. osop=sop, oeop=ieop sampled with z3; both low when oval=0. odat and oerr hold their value between pulses.
- icode is latched at group start; a change mid-group has no effect on the current group.
- Decode (all arithmetic 3-bit mod 8):
  - d1=z1-z0, d2=z2-z0.
  - Code 0: x={3'b0, z0[2],d1[2],d2[2],z0[1],d3[2],d1[1],d2[1],z0[0],d3[1]}, with d3=z3-z1-z2+z0. Equivalently:
    - x8,x5,x1 = z0[2:0]
    - x7,x3 = d1[2:1]
    - x6,x2 = d2[2:1]
    - x4,x0 = d3[2:1]
    - err = d1[0]|d2[0]|d3[0]
  - Code 1:
    - x9,x6,x2 = z0
    - x8,x4,x0 = d1
    - x7,x3 = d2[2:1]
    - d3 = z3-z0-{d1[2:1],0}-d2
    - x5,x1 = d3[2:1]
    - err = d2[0] | (d3[0]^d1[0])
  - Code 2:
    - x10,x7,x3 = z0
    - x9,x5,x1 = d1
    - x8,x4,x0 = d2
    - d3 = z3-z0-d1-d2
    - x6,x2 = d3[2:1]
    - err = d3[0]
  - Code 3:
    - x11,x8,x4 = z0
    - x10,x6,x2 = d1
    - x9,x5,x1 = d2
    - d3 = z3-z0-d1-d2
    - x7,x3,x0 = d3
    - err = 0
- Async reset mid-group: group lost; first output after reset requires a fresh ival.

Optional Feature:
- Macro TCM_DEC_DEMAPPER_ERR_CNT_EN.
- When defined, adds output oerr_cnt[15:0], a saturating count (stops at 16'hFFFF) of oval&oerr words in the current frame.
  - Counter clears on a group with sop=1; that group's error is counted from 0.
  - Value is captured into oerr_cnt on the oval with oeop=1 and held until the next frame end.
  - Reset value 0.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Code 0, group 7,5,5,1 with isop=1 and ieop=1 → one oval pulse 1 iclk after 4th strobe: odat=12'h1FF, oerr=0, osop=1, oeop=1.
- Code 0, group 7,4,5,1 → oerr=1 (d1=5, LSB set); odat produced regardless.
- Code 3, group 7,6,6,4 → odat=12'hFFF, oerr=0. Code 3, group 0,0,0,0 → odat=12'h000.
- Early restart: ival on symbols 1 and 3 of the stream, then symbols 4,5,6 → no output for the aborted group; one output for the restarted group.
- icode switched 0→2 on 2nd symbol → group decoded with code 0. i1sps held low or iclkena=0 for 5 cycles mid-group → no state change; result equals the uninterrupted case.
- ERR_CNT_EN: 3-group frame with 2 erroneous groups → oerr_cnt=2 at oeop. 70000 error groups in one frame → oerr_cnt=16'hFFFF.
